// File: rtl/frogger_pkg.sv
// frogger_pkg -- constants shared by the frog move-input path.
//   DIR_*                   : bit index of each direction in btn_n and in the internal
//                             direction vectors (L=3, U=2, D=1, R=0).
//   *_DEFAULT               : default timing parameters for move_input_conditioner.
//   max_u                   : helper used to size counters that must hold either of two limits.
package frogger_pkg;

    localparam int unsigned DIR_L = 3;
    localparam int unsigned DIR_U = 2;
    localparam int unsigned DIR_D = 1;
    localparam int unsigned DIR_R = 0;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned REPEAT_DELAY_DEFAULT    = 16;
    localparam int unsigned REPEAT_PERIOD_DEFAULT   = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- one button: 2-flop synchronizer, inversion to an active-high level, and a
// persistence-based debouncer.
//   clk     : system clock
//   reset   : synchronous, active-high; forces the button into its pressed state so a button
//             held through reset never looks like a fresh press
//   raw_n   : asynchronous, active-low button input
//   stable  : debounced active-high level
//   press   : high for the one cycle after stable rises 0->1
module btn_debounce
    import frogger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic stable,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    assign level = ~sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Raw low is the pressed state.
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
        end else begin
            sync1       <= raw_n;
            sync2       <= sync1;
            stable_prev <= stable;
            if (level == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // The new level has now persisted DEBOUNCE_CYCLES cycles.
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_prev;

endmodule

// File: rtl/move_input_conditioner.sv
// move_input_conditioner -- turns four raw active-low direction buttons into single-cycle move
// pulses for the frog cell array.
//   clk     : system clock
//   reset   : synchronous, active-high
//   btn_n   : asynchronous active-low buttons, [3]=L [2]=U [1]=D [0]=R
//   L/U/D/R : registered single-cycle move pulses, at most one high per cycle
//   move    : L|U|D|R
// A press is accepted only when it is the only button whose debounced level is high.
// Optional feature: define FROG_AUTOREPEAT_EN to compile in the auto-repeat FSM
// (IDLE -> DELAY -> REPEAT), which repeats the held direction after REPEAT_DELAY cycles and then
// every REPEAT_PERIOD cycles. Without it each accepted press gives exactly one pulse.
module move_input_conditioner
    import frogger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_n,
    output logic       L,
    output logic       U,
    output logic       D,
    output logic       R,
    output logic       move
);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("move_input_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [3:0] stable;
    logic [3:0] press;
    logic [3:0] accept;
    logic [3:0] pulse_d;
    logic [3:0] pulse_q;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw_n (btn_n[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

    // A rising button implies its own stable bit is set, so "sole press and nothing else held"
    // reduces to the stable vector being exactly that button.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            if (press[i] && (stable == (4'b0001 << i))) begin
                accept[i] = 1'b1;
            end
        end
    end

`ifdef FROG_AUTOREPEAT_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_next;
    logic [3:0]    rdir;
    logic [3:0]    rdir_next;
    logic [3:0]    rep_pulse;

    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        rdir_next  = rdir;
        rep_pulse  = '0;
        unique case (state)
            ST_IDLE: begin
                if (|accept) begin
                    state_next = ST_DELAY;
                    rcnt_next  = '0;
                    rdir_next  = accept;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // Release of the held button or any other button going stable-pressed
                // both show up as the stable vector no longer matching the held direction.
                if (stable != rdir) begin
                    state_next = ST_IDLE;
                    rcnt_next  = '0;
                end else if (rcnt == ((state == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    rep_pulse  = rdir;
                    state_next = ST_REPEAT;
                    rcnt_next  = '0;
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            rdir  <= '0;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
            rdir  <= rdir_next;
        end
    end

    assign pulse_d = accept | rep_pulse;
`else
    assign pulse_d = accept;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign L    = pulse_q[DIR_L];
    assign U    = pulse_q[DIR_U];
    assign D    = pulse_q[DIR_D];
    assign R    = pulse_q[DIR_R];
    assign move = |pulse_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner -- directed bench for move_input_conditioner (default parameters).
// Cycle numbering: stimulus changes 1ns after a rising edge; the next rising edge is cycle 1 and
// outputs are observed 1ns after each edge. A press first sampled on edge 1 pulses after edge 7.
module tb_move_input_conditioner;
    import frogger_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] btn_n;
    logic       L;
    logic       U;
    logic       D;
    logic       R;
    logic       move;
    logic [3:0] outs;

    int checks;
    int failures;
    int cyc;
    int pcnt[4];
    int multi_hot;
    int move_bad;
    int d_cycles[$];

    move_input_conditioner dut (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_n),
        .L    (L),
        .U    (U),
        .D    (D),
        .R    (R),
        .move (move)
    );

    assign outs = {L, U, D, R};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_log();
        cyc = 0;
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
        multi_hot = 0;
        move_bad  = 0;
        d_cycles.delete();
    endtask

    // Advance one cycle and log what the outputs did.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (outs[i] === 1'b1) begin
                    pcnt[i]++;
                    if (i == DIR_D) d_cycles.push_back(cyc);
                end
            end
            if ($countones(outs) > 1) multi_hot++;
            if (move !== (|outs)) move_bad++;
        end
    endtask

    task automatic settle();
        btn_n = 4'b1111;
        step(14);
    endtask

    task automatic test_reset();
        btn_n = 4'b1111;
        reset = 1'b1;
        clear_log();
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if ({outs, move} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %b want 00000", k, {outs, move});
            end
        end
        reset = 1'b0;
        clear_log();
        step(14);
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL reset_release_no_pulse: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
    endtask

    task automatic test_single_press();
        clear_log();
        btn_n = 4'b0111;
        step(6);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL l_press_early: got %b want 0000 at cycle 6", outs);
        end
        step(1);
        checks++;
        if (outs !== 4'b1000) begin
            failures++;
            $display("FAIL l_press_pulse: got %b want 1000 at cycle 7", outs);
        end
        step(1);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL l_press_width: got %b want 0000 at cycle 8", outs);
        end
        step(2);
        settle();
        checks++;
        if (pcnt[DIR_L] !== 1 || (pcnt[DIR_U] + pcnt[DIR_D] + pcnt[DIR_R]) !== 0) begin
            failures++;
            $display("FAIL l_press_count: got L=%0d others=%0d want L=1 others=0",
                     pcnt[DIR_L], pcnt[DIR_U] + pcnt[DIR_D] + pcnt[DIR_R]);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        btn_n = 4'b1011;
        step(2);
        btn_n = 4'b1111;
        step(12);
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL glitch_no_pulse: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
        // If the glitch had flipped U's stable level, this press would not rise.
        clear_log();
        btn_n = 4'b1011;
        step(7);
        checks++;
        if (outs !== 4'b0100) begin
            failures++;
            $display("FAIL glitch_then_u_press: got %b want 0100 at cycle 7", outs);
        end
        step(2);
        settle();
    endtask

    task automatic test_simultaneous();
        clear_log();
        btn_n = 4'b0110;
        step(16);
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL lr_same_cycle: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
        settle();
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL lr_release: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
        clear_log();
        btn_n = 4'b1011;
        step(7);
        checks++;
        if (outs !== 4'b0100) begin
            failures++;
            $display("FAIL u_after_lr: got %b want 0100 at cycle 7", outs);
        end
        step(2);
        settle();
        checks++;
        if (pcnt[DIR_U] !== 1) begin
            failures++;
            $display("FAIL u_after_lr_count: got %0d U pulses want 1", pcnt[DIR_U]);
        end
    endtask

    task automatic test_held_through_reset();
        clear_log();
        btn_n = 4'b1110;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(30);
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL r_held_through_reset: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
        settle();
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL r_release_after_reset: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
        clear_log();
        btn_n = 4'b1110;
        step(7);
        checks++;
        if (outs !== 4'b0001) begin
            failures++;
            $display("FAIL r_repress: got %b want 0001 at cycle 7", outs);
        end
        step(2);
        settle();
        checks++;
        if (pcnt[DIR_R] !== 1) begin
            failures++;
            $display("FAIL r_repress_count: got %0d R pulses want 1", pcnt[DIR_R]);
        end
    endtask

    task automatic test_reset_abort();
        clear_log();
        btn_n = 4'b0111;
        step(4);
        reset = 1'b1;
        btn_n = 4'b1111;
        step(2);
        reset = 1'b0;
        step(20);
        checks++;
        if ((pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]) !== 0) begin
            failures++;
            $display("FAIL reset_mid_debounce: got %0d pulses want 0",
                     pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]);
        end
    endtask

    task automatic test_hold_d();
        int exp_cycles[$];
        int n_before;
`ifdef FROG_AUTOREPEAT_EN
        exp_cycles = '{7, 23, 31, 39, 47, 55};
`else
        exp_cycles = '{7};
`endif
        clear_log();
        btn_n = 4'b1101;
        step(56);
        checks++;
        if (d_cycles.size() !== exp_cycles.size()) begin
            failures++;
            $display("FAIL hold_d_count: got %0d D pulses want %0d",
                     d_cycles.size(), exp_cycles.size());
        end else begin
            for (int i = 0; i < exp_cycles.size(); i++) begin
                checks++;
                if (d_cycles[i] !== exp_cycles[i]) begin
                    failures++;
                    $display("FAIL hold_d_pulse%0d: got cycle %0d want cycle %0d",
                             i, d_cycles[i], exp_cycles[i]);
                end
            end
        end
        // U joins while D is still held: repeat must stop and U must be dropped.
        n_before = d_cycles.size();
        btn_n = 4'b1001;
        step(30);
        checks++;
        if (d_cycles.size() !== n_before || pcnt[DIR_U] !== 0) begin
            failures++;
            $display("FAIL hold_d_then_u: got D=%0d U=%0d want D=%0d U=0",
                     d_cycles.size(), pcnt[DIR_U], n_before);
        end
        settle();
        checks++;
        if ((pcnt[DIR_L] + pcnt[DIR_U] + pcnt[DIR_R]) !== 0) begin
            failures++;
            $display("FAIL hold_d_others: got %0d other pulses want 0",
                     pcnt[DIR_L] + pcnt[DIR_U] + pcnt[DIR_R]);
        end
    endtask

    task automatic test_invariants(input int total_multi, input int total_move);
        checks++;
        if (total_multi !== 0) begin
            failures++;
            $display("FAIL onehot_outputs: got %0d multi-hot cycles want 0", total_multi);
        end
        checks++;
        if (total_move !== 0) begin
            failures++;
            $display("FAIL move_is_or: got %0d bad cycles want 0", total_move);
        end
    endtask

    int acc_multi;
    int acc_move;

    initial begin
        checks    = 0;
        failures  = 0;
        acc_multi = 0;
        acc_move  = 0;
        reset     = 1'b1;
        btn_n     = 4'b1111;
        clear_log();

        test_reset();
        acc_multi += multi_hot; acc_move += move_bad;
        test_single_press();
        acc_multi += multi_hot; acc_move += move_bad;
        test_glitch();
        acc_multi += multi_hot; acc_move += move_bad;
        test_simultaneous();
        acc_multi += multi_hot; acc_move += move_bad;
        test_held_through_reset();
        acc_multi += multi_hot; acc_move += move_bad;
        test_reset_abort();
        acc_multi += multi_hot; acc_move += move_bad;
        test_hold_d();
        acc_multi += multi_hot; acc_move += move_bad;
        test_invariants(acc_multi, acc_move);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
